if_unit: RTL and testbench
==========================

IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset, sampled on the CLK rising edge.
REQ-003 SHALL have port STALL, input, 1, from hazard detection; 1 = decode cannot accept a new instruction this cycle.
REQ-004 SHALL have port BRANCH_SEL, input, 1, redirect request from the execute stage.
REQ-005 SHALL have port BRANCH_TARGET, input, 32, redirect address; bits [1:0] ignored and treated as 00.
REQ-006 SHALL have port IMEM_READDATA, input, 32, instruction word; valid in a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
REQ-007 SHALL have port IMEM_BUSYWAIT, input, 1, 1 = memory access not complete.
REQ-008 SHALL have port IMEM_READ, output, 1, instruction memory read request.
REQ-009 SHALL have port IMEM_ADDRESS, output, 32, word-aligned fetch address.
REQ-010 SHALL have port INSTRUCTION_IFID, output, 32, IF/ID instruction register.
REQ-011 SHALL have port PC_IFID, output, 32, PC of INSTRUCTION_IFID.
REQ-012 SHALL have port PC_PLUS4_IFID, output, 32, PC_IFID+4 mod 2^32.
REQ-013 SHALL have port VALID_IFID, output, 1, 1 = INSTRUCTION_IFID is a real instruction, 0 = bubble.

Function
REQ-014 SHALL implement states IDLE, FETCH, HOLD, DRAIN.
REQ-015 IDLE: IMEM_READ=0; next state FETCH unconditionally.
REQ-016 FETCH: IMEM_READ=1, IMEM_ADDRESS=PC; fetch completes in a cycle with IMEM_BUSYWAIT=0.
REQ-017 Completion with STALL=0, BRANCH_SEL=0: IF/ID loads {IMEM_READDATA, PC, PC+4, VALID=1}; PC<=PC+4; stay FETCH (back-to-back fetch, 1 instruction/cycle at zero wait).
REQ-018 Completion with STALL=1, BRANCH_SEL=0: word and PC captured in a one-entry hold buffer; IF/ID unchanged; PC<=PC+4; next state HOLD.
REQ-019 HOLD: IMEM_READ=0; while STALL=1 IF/ID and buffer unchanged; first cycle STALL=0: IF/ID loads buffer with VALID=1, next state FETCH.
REQ-020 No completion and STALL=0 in FETCH: IF/ID loads bubble {32'h00000013, PC_IFID unchanged, VALID=0}; with STALL=1 IF/ID unchanged.
REQ-021 BRANCH_SEL=1 has priority over STALL and over any completion in every state: PC<=BRANCH_TARGET&~3; IF/ID loads bubble (NOP, VALID=0); hold buffer discarded; any word completing that cycle discarded.
REQ-022 Redirect while FETCH with IMEM_BUSYWAIT=1: next state DRAIN, old address latched.
REQ-023 DRAIN: IMEM_READ=1, IMEM_ADDRESS=latched old address (never changes mid-access); on IMEM_BUSYWAIT=0 data discarded, next state FETCH at new PC.
REQ-024 Redirect during DRAIN: PC replaced with newest target, remain DRAIN.
REQ-025 Redirect in FETCH with IMEM_BUSYWAIT=0, in HOLD or in IDLE: next state FETCH.
REQ-026 PC+4 SHALL wrap: 32'hFFFFFFFC -> 32'h00000000.
REQ-027 IMEM_ADDRESS[1:0] SHALL always be 00.

Reset
REQ-028 RESET=1 at a rising edge: PC=0, state IDLE, buffer empty, INSTRUCTION_IFID=32'h00000013, PC_IFID=0, PC_PLUS4_IFID=4, VALID_IFID=0; IMEM_READ=0 while in IDLE.
REQ-029 RESET SHALL override all inputs including BRANCH_SEL; reset mid-access abandons it without DRAIN; first fetch at address 0 two cycles after release... precisely: IDLE one cycle, then FETCH.

Verification
REQ-030 Reset, zero-wait memory, STALL=0: IMEM_ADDRESS 0,4,8 in consecutive cycles; IF/ID shows PC_IFID 0,4,8 with VALID=1.
REQ-031 IMEM_BUSYWAIT=1 for 3 cycles at address 8: IMEM_ADDRESS held at 8, IF/ID bubbles (VALID=0), then instruction at 8 with VALID=1.
REQ-032 STALL=1 when word at 0x10 completes: IMEM_READ drops, IF/ID frozen; STALL=0 -> PC_IFID=0x10, next fetch 0x14.
REQ-033 BRANCH_SEL=1, BRANCH_TARGET=0x103 during busy access at 0x20: IMEM_ADDRESS stays 0x20 until busywait low, data dropped, next fetch 0x100.
REQ-034 PC=0xFFFFFFFC, zero-wait: PC_PLUS4_IFID=0, next IMEM_ADDRESS=0.
REQ-035 BRANCH_SEL=1 and STALL=1 in same HOLD cycle: buffer dropped, IF/ID=NOP VALID=0, next fetch at target.

Source files
------------

// File: rtl/if_unit.sv
// Instruction-fetch stage with an IF/ID pipeline register.
// A four-state controller (IDLE, FETCH, HOLD, DRAIN) issues word-aligned
// reads to instruction memory and tolerates memory wait states. A one-entry
// hold buffer keeps a word that arrives while decode is stalled. Branch
// redirects take priority over stalls and completions. A redirect that lands
// mid-access lets the outstanding access drain at its original address
// before fetching resumes at the new PC.
module if_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_SEL,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] INSTRUCTION_IFID,
  output logic [31:0] PC_IFID,
  output logic [31:0] PC_PLUS4_IFID,
  output logic        VALID_IFID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Canonical NOP (addi x0, x0, 0) used for bubbles.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Registered state
  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] hold_instr_r;
  logic [31:0] hold_pc_r;
  logic        hold_full_r;
  logic        imem_read_r;
  logic [31:0] imem_address_r;
  logic [31:0] instr_ifid_r;
  logic [31:0] pc_ifid_r;
  logic [31:0] pc_plus4_ifid_r;
  logic        valid_ifid_r;

  // Next-state values
  state_t      state_s;
  logic [31:0] pc_s;
  logic [31:0] hold_instr_s;
  logic [31:0] hold_pc_s;
  logic        hold_full_s;
  logic        imem_read_s;
  logic [31:0] imem_address_s;
  logic [31:0] instr_ifid_s;
  logic [31:0] pc_ifid_s;
  logic [31:0] pc_plus4_ifid_s;
  logic        valid_ifid_s;

  logic [31:0] target_s;
  logic [31:0] pc_inc_s;

  assign target_s = {BRANCH_TARGET[31:2], 2'b00};
  assign pc_inc_s = pc_r + 32'd4;

  // Next-state, next-PC, hold-buffer and IF/ID computation.
  always_comb begin
    state_s         = state_r;
    pc_s            = pc_r;
    hold_instr_s    = hold_instr_r;
    hold_pc_s       = hold_pc_r;
    hold_full_s     = hold_full_r;
    instr_ifid_s    = instr_ifid_r;
    pc_ifid_s       = pc_ifid_r;
    pc_plus4_ifid_s = pc_plus4_ifid_r;
    valid_ifid_s    = valid_ifid_r;

    case (state_r)
      IDLE: begin
        state_s = FETCH;
        if (BRANCH_SEL) begin
          pc_s         = target_s;
          instr_ifid_s = NOP_WORD;
          valid_ifid_s = 1'b0;
          hold_full_s  = 1'b0;
        end else begin
          pc_s = pc_r;
        end
      end

      FETCH: begin
        if (BRANCH_SEL) begin
          // Redirect wins; any word completing now is dropped.
          pc_s         = target_s;
          instr_ifid_s = NOP_WORD;
          valid_ifid_s = 1'b0;
          hold_full_s  = 1'b0;
          if (IMEM_BUSYWAIT) begin
            state_s = DRAIN;
          end else begin
            state_s = FETCH;
          end
        end else if (!IMEM_BUSYWAIT) begin
          pc_s = pc_inc_s;
          if (!STALL) begin
            instr_ifid_s    = IMEM_READDATA;
            pc_ifid_s       = pc_r;
            pc_plus4_ifid_s = pc_inc_s;
            valid_ifid_s    = 1'b1;
          end else begin
            // Decode is busy: park the word until it can accept it.
            hold_instr_s = IMEM_READDATA;
            hold_pc_s    = pc_r;
            hold_full_s  = 1'b1;
            state_s      = HOLD;
          end
        end else if (!STALL) begin
          instr_ifid_s = NOP_WORD;
          valid_ifid_s = 1'b0;
        end else begin
          state_s = FETCH;
        end
      end

      HOLD: begin
        if (BRANCH_SEL) begin
          pc_s         = target_s;
          instr_ifid_s = NOP_WORD;
          valid_ifid_s = 1'b0;
          hold_full_s  = 1'b0;
          state_s      = FETCH;
        end else if (!STALL) begin
          if (hold_full_r) begin
            instr_ifid_s    = hold_instr_r;
            pc_ifid_s       = hold_pc_r;
            pc_plus4_ifid_s = hold_pc_r + 32'd4;
            valid_ifid_s    = 1'b1;
          end else begin
            instr_ifid_s = NOP_WORD;
            valid_ifid_s = 1'b0;
          end
          hold_full_s = 1'b0;
          state_s     = FETCH;
        end else begin
          state_s = HOLD;
        end
      end

      DRAIN: begin
        if (BRANCH_SEL) begin
          // Newest target replaces the pending one; access still draining.
          pc_s         = target_s;
          instr_ifid_s = NOP_WORD;
          valid_ifid_s = 1'b0;
          state_s      = DRAIN;
        end else begin
          if (!IMEM_BUSYWAIT) begin
            state_s = FETCH;
          end else begin
            state_s = DRAIN;
          end
          if (!STALL) begin
            instr_ifid_s = NOP_WORD;
            valid_ifid_s = 1'b0;
          end else begin
            valid_ifid_s = valid_ifid_r;
          end
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // Memory interface follows the state being entered. DRAIN keeps the
    // address of the access that is still outstanding.
    imem_read_s = (state_s == FETCH) || (state_s == DRAIN);
    if (state_s == DRAIN) begin
      imem_address_s = imem_address_r;
    end else begin
      imem_address_s = pc_s;
    end
  end

  // Controller, PC, hold buffer, memory interface and IF/ID registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r         <= IDLE;
      pc_r            <= 32'h0000_0000;
      hold_instr_r    <= NOP_WORD;
      hold_pc_r       <= 32'h0000_0000;
      hold_full_r     <= 1'b0;
      imem_read_r     <= 1'b0;
      imem_address_r  <= 32'h0000_0000;
      instr_ifid_r    <= NOP_WORD;
      pc_ifid_r       <= 32'h0000_0000;
      pc_plus4_ifid_r <= 32'h0000_0004;
      valid_ifid_r    <= 1'b0;
    end else begin
      state_r         <= state_s;
      pc_r            <= pc_s;
      hold_instr_r    <= hold_instr_s;
      hold_pc_r       <= hold_pc_s;
      hold_full_r     <= hold_full_s;
      imem_read_r     <= imem_read_s;
      imem_address_r  <= imem_address_s;
      instr_ifid_r    <= instr_ifid_s;
      pc_ifid_r       <= pc_ifid_s;
      pc_plus4_ifid_r <= pc_plus4_ifid_s;
      valid_ifid_r    <= valid_ifid_s;
    end
  end

  assign IMEM_READ        = imem_read_r;
  assign IMEM_ADDRESS     = {imem_address_r[31:2], 2'b00};
  assign INSTRUCTION_IFID = instr_ifid_r;
  assign PC_IFID          = pc_ifid_r;
  assign PC_PLUS4_IFID    = pc_plus4_ifid_r;
  assign VALID_IFID       = valid_ifid_r;

endmodule

// File: tb/tb_if_unit.sv
// Directed testbench for if_unit: a table of per-cycle vectors plus a few
// hand-written reset/redirect sequences.
module tb_if_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_SEL;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] INSTRUCTION_IFID;
  logic [31:0] PC_IFID;
  logic [31:0] PC_PLUS4_IFID;
  logic        VALID_IFID;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        busy;
    logic        e_read;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  if_unit dut (
    .CLK(CLK),
    .RESET(RESET),
    .STALL(STALL),
    .BRANCH_SEL(BRANCH_SEL),
    .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_READDATA(IMEM_READDATA),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .IMEM_READ(IMEM_READ),
    .IMEM_ADDRESS(IMEM_ADDRESS),
    .INSTRUCTION_IFID(INSTRUCTION_IFID),
    .PC_IFID(PC_IFID),
    .PC_PLUS4_IFID(PC_PLUS4_IFID),
    .VALID_IFID(VALID_IFID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory contents: a recognisable word per address.
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign IMEM_READDATA = IMEM_READ ? w(IMEM_ADDRESS) : 32'hBAD0_BAD0;

  function automatic vec_t mk(input logic stall, input logic br, input logic [31:0] tgt,
                              input logic busy, input logic e_read, input logic [31:0] e_addr,
                              input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic e_valid);
    vec_t v;
    v.stall = stall; v.br = br; v.tgt = tgt; v.busy = busy;
    v.e_read = e_read; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_read, input logic [31:0] e_addr,
                           input logic [31:0] e_instr, input logic [31:0] e_pc,
                           input logic e_valid);
    logic [31:0] e_plus4;
    e_plus4 = e_pc + 32'd4;
    chk({tag, ".read"},   {31'd0, IMEM_READ},  {31'd0, e_read});
    chk({tag, ".addr"},   IMEM_ADDRESS,        e_addr);
    chk({tag, ".instr"},  INSTRUCTION_IFID,    e_instr);
    chk({tag, ".pc"},     PC_IFID,             e_pc);
    chk({tag, ".pc4"},    PC_PLUS4_IFID,       e_plus4);
    chk({tag, ".valid"},  {31'd0, VALID_IFID}, {31'd0, e_valid});
  endtask

  task automatic drive(input logic rst, input logic stall, input logic br,
                       input logic [31:0] tgt, input logic busy);
    RESET = rst; STALL = stall; BRANCH_SEL = br; BRANCH_TARGET = tgt; IMEM_BUSYWAIT = busy;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Inputs applied before an edge; expected outputs are after that edge.
    //                 stall br  tgt            busy rd    addr           instr             pc_ifid        valid
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, NOP,              32'h0000_0000, 1'b0)); // IDLE->FETCH
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, w(32'h0),         32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0008, w(32'h4),         32'h0000_0004, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, NOP,              32'h0000_0004, 1'b0)); // wait x3
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, NOP,              32'h0000_0004, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, NOP,              32'h0000_0004, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_000C, w(32'h8),         32'h0000_0008, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0010, w(32'hC),         32'h0000_000C, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0014, w(32'hC),         32'h0000_000C, 1'b1)); // stall at 0x10
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0014, w(32'hC),         32'h0000_000C, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0014, w(32'h10),        32'h0000_0010, 1'b1)); // release
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0018, w(32'h14),        32'h0000_0014, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_001C, w(32'h18),        32'h0000_0018, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0020, w(32'h1C),        32'h0000_001C, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1, 32'h0000_0020, NOP,              32'h0000_001C, 1'b0)); // branch busy
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0020, NOP,              32'h0000_001C, 1'b0)); // drain
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0100, NOP,              32'h0000_001C, 1'b0)); // dropped
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0104, w(32'h100),       32'h0000_0100, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0104, NOP,              32'h0000_0100, 1'b0)); // branch busy
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0302, 1'b1, 1'b1, 32'h0000_0104, NOP,              32'h0000_0100, 1'b0)); // re-branch in drain
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0300, NOP,              32'h0000_0100, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0304, w(32'h300),       32'h0000_0300, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0308, w(32'h300),       32'h0000_0300, 1'b1)); // to HOLD
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040, NOP,              32'h0000_0300, 1'b0)); // br+stall in HOLD
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0044, w(32'h40),        32'h0000_0040, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFC, NOP,              32'h0000_0040, 1'b0)); // branch, word dropped
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, w(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1)); // wrap
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, w(32'h0),         32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, w(32'h0),         32'h0000_0000, 1'b1)); // stall, busy
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0008, w(32'h4),         32'h0000_0004, 1'b1));

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    check_all("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].busy);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr,
                vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_valid);
    end

    // Reset during a busy access with a simultaneous branch: no DRAIN.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0500, 1'b1);
    step();
    check_all("rst_mid", 1'b0, 32'h0, NOP, 32'h0, 1'b0);

    // Branch taken while in IDLE goes straight to FETCH at the target.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0081, 1'b0);
    step();
    check_all("idle_br", 1'b1, 32'h0000_0080, NOP, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_all("idle_br2", 1'b1, 32'h0000_0084, w(32'h80), 32'h0000_0080, 1'b1);

    // Plain reset release: IDLE for one cycle, then FETCH at 0.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_all("rel1", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    step();
    check_all("rel2", 1'b1, 32'h4, w(32'h0), 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
